// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Arbitrates the three memory clients (instruction fetch, load unit, store
//   unit) onto the byte-serial memory controller. Exactly one word
//   transaction is outstanding at a time. Fetches use the controller's
//   instruction port; loads and stores use its data port. A completed
//   transaction returns a one-cycle done pulse to its client, carrying the
//   read word for fetches and loads.
//
//   The controller's ready flags are sticky: they stay high from the end of
//   one transaction until the controller starts the next one. The arbiter
//   therefore ignores ready in the first BUSY cycle. It also drops valid in
//   the same cycle that a fresh ready is seen, so the controller never
//   restarts the transaction it has just finished.
//
// Handshake (client side):
//   A client raises *_req (a level) and holds it until its *_done pulse.
//   *_done is high for exactly one cycle. *_rdata is valid in that cycle and
//   holds its value until the next completion for that client. A request
//   that is still high in the done cycle is treated as a new request.
//
// Handshake (controller side):
//   mc_*_valid is high while the arbiter wants the controller to run the
//   transaction. The controller starts when it sees valid while it is idle.
//   It raises mc_*_ready (sticky) together with mc_*_res when it finishes.
//
// Optional feature (compile-time macro MEM_ARB_STARVE_GUARD_EN):
//   When defined, a starvation counter forces a fetch grant after
//   STARVE_LIMIT consecutive load/store grants made while if_req was high.
//   When undefined, arbitration is fixed priority st > ld > if, and the
//   counter logic is absent.
//
// Ports:
//   clk_in, rst_in       clock, synchronous active-high reset
//   rdy_in               global ready; low freezes every register
//   if_req/if_addr       fetch request   -> if_done/if_rdata
//   ld_req/ld_addr       load request    -> ld_done/ld_rdata
//   st_req/st_addr/st_wdata store request -> st_done
//   mc_inst_*            controller instruction port
//   mc_data_*            controller data port (mc_data_wr: 1 = write)
//   dbg_state            current FSM state (0 = IDLE, 1 = BUSY)
//   dbg_owner            owner of the current/last transaction (0 IF, 1 LD, 2 ST)
// ----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,

    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    output logic        ld_done,
    output logic [31:0] ld_rdata,

    input  logic        st_req,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wdata,
    output logic        st_done,

    output logic        mc_inst_valid,
    output logic [31:0] mc_inst_addr,
    input  logic        mc_inst_ready,
    input  logic [31:0] mc_inst_res,

    output logic        mc_data_valid,
    output logic [31:0] mc_data_addr,
    output logic [31:0] mc_data_data,
    output logic        mc_data_wr,
    input  logic        mc_data_ready,
    input  logic [31:0] mc_data_res,

    output logic [0:0]  dbg_state,
    output logic [1:0]  dbg_owner
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [1:0] OWN_IF = 2'd0;
    localparam logic [1:0] OWN_LD = 2'd1;
    localparam logic [1:0] OWN_ST = 2'd2;

    logic [0:0]  state;
    logic [1:0]  owner;
    logic        first;       // high in the first BUSY cycle: ready flags are stale
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        wr_q;

    logic        grant_if;
    logic        grant_ld;
    logic        grant_st;
    logic        grant_any;
    logic        force_if;
    logic        owner_ready;
    logic        complete;

    // ------------------------------------------------------------------
    // Starvation guard
    // ------------------------------------------------------------------
`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [CNT_W-1:0] starve_cnt;

    assign force_if = if_req && (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Counts load/store grants taken while a fetch was waiting. It only moves
    // in IDLE, so a long BUSY period does not affect it.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            starve_cnt <= '0;
        end else if (rdy_in && (state == S_IDLE)) begin
            if (grant_if || !if_req) begin
                starve_cnt <= '0;
            end else if ((grant_ld || grant_st) &&
                         (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end
`else
    // Pure fixed priority: no forced fetch. The configuration parameters are
    // kept on the interface so both builds share one instantiation.
    logic [CNT_W-1:0] unused_cfg;

    assign unused_cfg = CNT_W'(STARVE_LIMIT);
    assign force_if   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Arbitration (evaluated only in IDLE)
    // ------------------------------------------------------------------
    always_comb begin
        grant_if = 1'b0;
        grant_ld = 1'b0;
        grant_st = 1'b0;
        if (state == S_IDLE) begin
            if (force_if) begin
                grant_if = 1'b1;
            end else if (st_req) begin
                grant_st = 1'b1;
            end else if (ld_req) begin
                grant_ld = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    assign grant_any = grant_if || grant_ld || grant_st;

    // Only the port used by the owner is watched; the other port's ready may
    // still be sticky from an older transaction.
    assign owner_ready = (owner == OWN_IF) ? mc_inst_ready : mc_data_ready;
    assign complete    = (state == S_BUSY) && !first && owner_ready;

    // ------------------------------------------------------------------
    // Main FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= S_IDLE;
            owner    <= OWN_IF;
            first    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            if_done  <= 1'b0;
            ld_done  <= 1'b0;
            st_done  <= 1'b0;
            if_rdata <= '0;
            ld_rdata <= '0;
        end else if (rdy_in) begin
            // Done pulses last exactly one (unfrozen) cycle.
            if_done <= 1'b0;
            ld_done <= 1'b0;
            st_done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        state <= S_BUSY;
                        first <= 1'b1;
                        if (grant_st) begin
                            owner   <= OWN_ST;
                            addr_q  <= st_addr;
                            wdata_q <= st_wdata;
                            wr_q    <= 1'b1;
                        end else if (grant_ld) begin
                            owner   <= OWN_LD;
                            addr_q  <= ld_addr;
                            wdata_q <= '0;
                            wr_q    <= 1'b0;
                        end else begin
                            owner   <= OWN_IF;
                            addr_q  <= if_addr;
                            wdata_q <= '0;
                            wr_q    <= 1'b0;
                        end
                    end
                end

                S_BUSY: begin
                    first <= 1'b0;
                    if (complete) begin
                        state <= S_IDLE;
                        case (owner)
                            OWN_IF: begin
                                if_rdata <= mc_inst_res;
                                if_done  <= 1'b1;
                            end
                            OWN_LD: begin
                                ld_rdata <= mc_data_res;
                                ld_done  <= 1'b1;
                            end
                            OWN_ST: begin
                                st_done  <= 1'b1;
                            end
                            default: begin
                            end
                        endcase
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Controller-side outputs
    // ------------------------------------------------------------------
    // Valid falls in the very cycle a fresh ready is visible, so the
    // controller never sees valid while idle after finishing this word.
    assign mc_inst_valid = (state == S_BUSY) && (owner == OWN_IF) &&
                           !(mc_inst_ready && !first);
    assign mc_data_valid = (state == S_BUSY) &&
                           ((owner == OWN_LD) || (owner == OWN_ST)) &&
                           !(mc_data_ready && !first);

    assign mc_inst_addr = addr_q;
    assign mc_data_addr = addr_q;
    assign mc_data_data = wdata_q;
    assign mc_data_wr   = wr_q;

    assign dbg_state = state;
    assign dbg_owner = owner;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the three memory clients (instruction fetch, load unit, store unit) and the byte-serial memory controller.
- Grants exactly one outstanding word transaction at a time.
- Drives the controller's instruction port for fetches and its data port for loads and stores.
- Returns per-client done pulses with read data; handles the controller's sticky ready flags and its idle-cycle restart behaviour.

Parameters:
STARVE_LIMIT, 4, number of consecutive load/store grants while ifetch waits before ifetch is forced to win
CNT_W, 3, width of starvation counter (must hold STARVE_LIMIT)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global ready; low freezes all state
if_req  input  1  fetch request, level, held until if_done
if_addr  input  32  fetch address
if_done  output  1  one-cycle pulse, fetch complete
if_rdata  output  32  fetch word, valid with if_done
ld_req  input  1  load request, level, held until ld_done
ld_addr  input  32  load address
ld_done  output  1  one-cycle pulse, load complete
ld_rdata  output  32  load word, valid with ld_done
st_req  input  1  store request, level, held until st_done
st_addr  input  32  store address
st_wdata  input  32  store word
st_done  output  1  one-cycle pulse, store complete
mc_inst_valid  output  1  to controller instruction port
mc_inst_addr  output  32  fetch address to controller
mc_inst_ready  input  1  controller instruction ready (sticky until next start)
mc_inst_res  input  32  controller instruction result
mc_data_valid  output  1  to controller data port
mc_data_addr  output  32  load/store address to controller
mc_data_data  output  32  store data to controller
mc_data_wr  output  1  1 = write
mc_data_ready  input  1  controller data ready (sticky until next start)
mc_data_res  input  32  controller data result

Behaviour:
- Reset (rst_in=1 at clk edge, any state, including mid-transaction):
  - State goes to IDLE.
  - All done pulses 0; if_rdata/ld_rdata 0.
  - mc_*_valid 0; addr/data/wr registers 0; starvation counter 0.
  - An in-flight controller transaction is abandoned; no done pulse is issued for it.
- rdy_in=0: no state, register or counter change; combinational outputs still follow registers.
- States: IDLE, BUSY.
- IDLE, arbitration among asserted requests:
  - Priority is st > ld > if.
  - Exception: if starvation counter == STARVE_LIMIT and if_req=1, if wins.
  - On grant: latch owner (IF/LD/ST), address, store data and wr; set first=1; go to BUSY.
  - No request: stay in IDLE.
  - Done pulses are never asserted in IDLE except in the cycle immediately after completion.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each ld/st grant made while if_req=1.
  - Clears on an if grant, and in any IDLE cycle with if_req=0.
- BUSY:
  - First cycle: ignore the controller ready flags, since they are stale from the prior transaction. Clear first.
  - Later cycles: watch only the ready of the port used by the owner: mc_inst_ready for IF, mc_data_ready for LD/ST.
  - When that ready=1: latch the result into the owner's rdata (stores latch nothing); pulse the owner's done next cycle; return to IDLE.
- Valid generation (combinational):
  - mc_inst_valid = BUSY && owner==IF && !(mc_inst_ready && !first).
  - mc_data_valid is analogous for LD/ST.
  - Purpose: valid drops in the same cycle ready is seen, so the controller cannot restart.
- Latency:
  - Grant is registered: request seen in IDLE at cycle N gives valid at N+1.
  - done = one cycle after ready.
  - Minimum turnaround between transactions is 1 IDLE cycle.
- Simultaneous events:
  - A request dropped while the client is unowned is simply not granted.
  - The owner must hold its request until its done pulse; dropping it early does not abort the transaction.
  - A new request may be sampled in the same IDLE cycle as the previous done pulse.
- Address/data are passed through unmodified: full 32 bits, no alignment check.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined: starvation counter and forced-ifetch rule active as described above.
- Undefined: pure fixed priority st > ld > if; the counter and the STARVE_LIMIT logic are absent; CNT_W is unused.

Test Plan:
- Reset then single fetch if_addr=0x0000_1000, controller model returns 0xDEADBEEF -> exactly one mc_inst_valid transaction at addr 0x1000; if_done pulse 1 cycle with if_rdata=0xDEADBEEF; mc_data_valid never asserted.
- st_req (addr 0x20, wdata 0x11223344) and ld_req (addr 0x24) asserted same cycle -> store issued first with mc_data_wr=1, data 0x11223344; load issued after st_done with mc_data_wr=0; ld_rdata = model word at 0x24.
- Controller leaves mc_data_ready stuck high from the previous store; a new load is issued -> the first BUSY cycle's ready is ignored; ld_done only after a fresh ready; exactly one transaction is observed.
- With MEM_ARB_STARVE_GUARD_EN, if_req held while ld_req is continuously re-asserted -> ifetch granted after 4 load grants. Without the macro -> ifetch waits until ld_req drops.
- rst_in pulsed during BUSY of a fetch -> next cycle IDLE, all valids 0, no if_done; a fresh request afterwards completes normally.
- rdy_in held low 3 cycles mid-BUSY -> state, valids and outputs unchanged; completion delayed by exactly 3 cycles.
